ultrasonic_scanner: RTL and testbench



---
 rtl/ultrasonic_scanner.sv | 226 ++++++++++++++++++++++
 tb/tb_ultrasonic_scanner.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_scanner.sv
// Round-robin multi-channel HC-SR04 ranging controller with built-in microsecond tick.
// Define ULTRASONIC_AVG_EN to report a 4-reading running average per channel.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | wait for the slot period to elapse (or first trigger after reset)
// S_TRIG    | drive trig[ch] for TRIG_US ticks
// S_WAIT    | wait for synchronised echo rise, give up at TIMEOUT_US+TRIG_US
// S_MEAS    | count echo width in microseconds
// S_CALC    | convert width to cm, write result, advance channel
// S_FAIL    | flag timeout for the channel, advance channel
module ultrasonic_scanner #(
   parameter int CLK_HZ     = 125_000_000,
   parameter int N_CH       = 4,
   parameter int DIST_W     = 9,
   parameter int SLOT_US    = 60_000,
   parameter int TRIG_US    = 10,
   parameter int TIMEOUT_US = 23_200
) (
   input  logic                                      clk,
   input  logic                                      reset_p,
   input  logic [N_CH-1:0]                           echo,
   output logic [N_CH-1:0]                           trig,
   output logic [N_CH*DIST_W-1:0]                    distance,
   output logic                                      valid,
   output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] valid_ch,
   output logic [N_CH-1:0]                           timeout
);
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int DIV    = CLK_HZ / 1_000_000;
   localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SLOT_W = $clog2(SLOT_US + TIMEOUT_US + TRIG_US + 1);
   localparam int TRIG_W = $clog2(TRIG_US + 1);
   localparam logic [DIST_W-1:0] DIST_MAX = '1;

   typedef enum logic [5:0] {
      S_IDLE = 6'b000001,
      S_TRIG = 6'b000010,
      S_WAIT = 6'b000100,
      S_MEAS = 6'b001000,
      S_CALC = 6'b010000,
      S_FAIL = 6'b100000
   } state_t;

   state_t              state, state_nxt;
   logic [DIV_W-1:0]    div_cnt;
   logic                usec_tick;
   logic                first;
   logic [CH_W-1:0]     ch;
   logic [SLOT_W-1:0]   slot_us;
   logic [TRIG_W-1:0]   trig_cnt;
   logic [15:0]         echo_us;
   logic [N_CH-1:0]     echo_s1, echo_s2, echo_s3;
   logic                rise_raw, fall_raw, rise, fall, go_trig;
   logic [15:0]         quot;
   logic [DIST_W-1:0]   raw;
   logic [DIST_W-1:0]   dist_r [N_CH];

   // The divider restarts on every trigger so slot and trigger timing are
   // exact multiples of the clock period measured from trigger rise.
   assign usec_tick = (div_cnt == '0);

   always_ff @(posedge clk) begin
      if (reset_p)                    div_cnt <= '0;
      else if (go_trig || usec_tick)  div_cnt <= DIV_W'(DIV - 1);
      else                            div_cnt <= div_cnt - DIV_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset_p) begin
         echo_s1 <= '0;
         echo_s2 <= '0;
         echo_s3 <= '0;
      end else begin
         echo_s1 <= echo;
         echo_s2 <= echo_s1;
         echo_s3 <= echo_s2;
      end
   end

   assign rise_raw = echo_s2[ch] & ~echo_s3[ch];
   assign fall_raw = ~echo_s2[ch] & echo_s3[ch];
   assign rise     = rise_raw & ~fall_raw;
   assign fall     = fall_raw & ~rise_raw;

   assign go_trig = (state == S_IDLE) &&
                    (first || (usec_tick && slot_us >= SLOT_W'(SLOT_US - 1)));

   always_ff @(posedge clk) begin
      if (reset_p) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (go_trig) state_nxt = S_TRIG;
         S_TRIG: if (usec_tick && trig_cnt == TRIG_W'(1)) state_nxt = S_WAIT;
         S_WAIT: begin
            if (rise)                                          state_nxt = S_MEAS;
            else if (slot_us >= SLOT_W'(TIMEOUT_US + TRIG_US)) state_nxt = S_FAIL;
         end
         S_MEAS: begin
            if (fall)                                state_nxt = S_CALC;
            else if (echo_us >= 16'(TIMEOUT_US))     state_nxt = S_FAIL;
         end
         S_CALC:  state_nxt = S_IDLE;
         S_FAIL:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_p) begin
         first    <= 1'b1;
         ch       <= '0;
         slot_us  <= '0;
         trig_cnt <= '0;
         echo_us  <= '0;
      end else begin
         if (go_trig) begin
            first    <= 1'b0;
            slot_us  <= '0;
            trig_cnt <= TRIG_W'(TRIG_US);
         end else begin
            if (usec_tick && slot_us != '1)      slot_us  <= slot_us + SLOT_W'(1);
            if (state == S_TRIG && usec_tick)    trig_cnt <= trig_cnt - TRIG_W'(1);
         end
         if (state == S_WAIT && rise)
            echo_us <= '0;
         else if (state == S_MEAS && usec_tick && echo_us != '1)
            echo_us <= echo_us + 16'd1;
         if (state == S_CALC || state == S_FAIL)
            ch <= (ch == CH_W'(N_CH - 1)) ? '0 : ch + CH_W'(1);
      end
   end

   assign quot = echo_us / 16'd58;
   assign raw  = (quot > 16'(DIST_MAX)) ? DIST_MAX : quot[DIST_W-1:0];

`ifdef ULTRASONIC_AVG_EN
   // Only the three previous readings are stored; the fourth is the new one.
   logic                pend;
   logic [CH_W-1:0]     pend_ch;
   logic [DIST_W-1:0]   pend_raw;
   logic [DIST_W-1:0]   hist [N_CH][3];
   logic [N_CH-1:0]     hist_ok;
   logic [DIST_W+1:0]   avg_sum;

   assign avg_sum = (DIST_W+2)'(pend_raw) + (DIST_W+2)'(hist[pend_ch][0]) +
                    (DIST_W+2)'(hist[pend_ch][1]) + (DIST_W+2)'(hist[pend_ch][2]);

   always_ff @(posedge clk) begin
      if (reset_p) begin
         valid    <= 1'b0;
         valid_ch <= '0;
         timeout  <= '0;
         pend     <= 1'b0;
         pend_ch  <= '0;
         pend_raw <= '0;
         hist_ok  <= '0;
         for (int k = 0; k < N_CH; k++) begin
            dist_r[k] <= '0;
            for (int j = 0; j < 3; j++) hist[k][j] <= '0;
         end
      end else begin
         valid <= 1'b0;
         pend  <= (state == S_CALC);
         if (state == S_CALC) begin
            pend_ch  <= ch;
            pend_raw <= raw;
         end
         if (pend) begin
            if (hist_ok[pend_ch]) begin
               dist_r[pend_ch]  <= avg_sum[DIST_W+1:2];
               hist[pend_ch][2] <= hist[pend_ch][1];
               hist[pend_ch][1] <= hist[pend_ch][0];
               hist[pend_ch][0] <= pend_raw;
            end else begin
               dist_r[pend_ch]  <= pend_raw;
               for (int j = 0; j < 3; j++) hist[pend_ch][j] <= pend_raw;
               hist_ok[pend_ch] <= 1'b1;
            end
            timeout[pend_ch] <= 1'b0;
            valid            <= 1'b1;
            valid_ch         <= pend_ch;
         end else if (state == S_FAIL) begin
            timeout[ch] <= 1'b1;
            valid       <= 1'b1;
            valid_ch    <= ch;
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (reset_p) begin
         valid    <= 1'b0;
         valid_ch <= '0;
         timeout  <= '0;
         for (int k = 0; k < N_CH; k++) dist_r[k] <= '0;
      end else begin
         valid <= 1'b0;
         if (state == S_CALC) begin
            dist_r[ch]  <= raw;
            timeout[ch] <= 1'b0;
            valid       <= 1'b1;
            valid_ch    <= ch;
         end else if (state == S_FAIL) begin
            timeout[ch] <= 1'b1;
            valid       <= 1'b1;
            valid_ch    <= ch;
         end
      end
   end
`endif

   always_comb begin
      trig = '0;
      if (state == S_TRIG) trig[ch] = 1'b1;
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_dist
      assign distance[k*DIST_W +: DIST_W] = dist_r[k];
   end

endmodule

// File: tb/tb_ultrasonic_scanner.sv
// Directed bench for ultrasonic_scanner, scaled to 2 MHz and short slots so a
// full multi-scan run stays small; echoes are driven per slot from a vector table.
module tb_ultrasonic_scanner;
   localparam int N_CH       = 4;
   localparam int DIST_W     = 4;
   localparam int CLK_HZ     = 2_000_000;
   localparam int SLOT_US    = 1500;
   localparam int TRIG_US    = 10;
   localparam int TIMEOUT_US = 1200;
   localparam int CPU        = CLK_HZ / 1_000_000;
   localparam int NV         = 13;

   logic                     clk = 1'b0;
   logic                     reset_p = 1'b1;
   logic [N_CH-1:0]          echo = '0;
   logic [N_CH-1:0]          trig;
   logic [N_CH*DIST_W-1:0]   distance;
   logic                     valid;
   logic [1:0]               valid_ch;
   logic [N_CH-1:0]          timeout;

   ultrasonic_scanner #(
      .CLK_HZ(CLK_HZ), .N_CH(N_CH), .DIST_W(DIST_W),
      .SLOT_US(SLOT_US), .TRIG_US(TRIG_US), .TIMEOUT_US(TIMEOUT_US)
   ) dut (
      .clk(clk), .reset_p(reset_p), .echo(echo), .trig(trig),
      .distance(distance), .valid(valid), .valid_ch(valid_ch), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // distance may only move on a valid cycle; trig must be one-hot or zero
   int                    glitch_cnt = 0;
   int                    multi_cnt  = 0;
   logic [N_CH*DIST_W-1:0] dist_prev = '0;
   logic                  rst_prev   = 1'b1;
   always @(negedge clk) begin
      if (!rst_prev && distance !== dist_prev && !valid) glitch_cnt <= glitch_cnt + 1;
      if ($countones(trig) > 1) multi_cnt <= multi_cnt + 1;
      dist_prev <= distance;
      rst_prev  <= reset_p;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   typedef struct {
      int ch;
      int dly;       // us from trig fall to echo rise
      int wid;       // echo width in us, -1 = no echo
      int exp_dist;  // expected distance[ch] after the slot
      bit exp_to;    // expected timeout[ch] after the slot
   } vec_t;

   vec_t vt [NV];

   // results captured by run_slot
   bit              g_got;
   int              g_vch, g_tw, g_lat, g_vi, g_rcyc;
   logic            g_vnext;
   logic [N_CH-1:0] g_trig;
   logic [N_CH*DIST_W-1:0] g_dist;
   logic [N_CH-1:0] g_to;

   task automatic run_slot(input int c, input int dly, input int wid);
      bit dropped;
      g_got = 0; g_vch = -1; g_tw = 0; g_lat = -1; g_vi = -1; g_rcyc = -1;
      g_vnext = 1'bx; g_trig = '0; g_dist = '0; g_to = '0;
      for (int i = 0; i < 4000 && !trig[c]; i++) begin @(posedge clk); #1; end
      if (!trig[c]) return;
      g_rcyc = cyc;
      g_trig = trig;
      while (trig[c] && g_tw < 100) begin g_tw++; @(posedge clk); #1; end
      repeat (dly * CPU) begin @(posedge clk); #1; end
      dropped = (wid < 0);
      if (wid >= 0) echo[c] = 1'b1;
      for (int i = 1; i < 6000; i++) begin
         @(posedge clk); #1;
         if (g_got && i == g_vi + 1) g_vnext = valid;
         if (!g_got && valid) begin
            g_got  = 1;
            g_vch  = int'(valid_ch);
            g_vi   = i;
            g_dist = distance;
            g_to   = timeout;
            if (dropped && wid >= 0) g_lat = i - wid * CPU;
         end
         if (wid >= 0 && i == wid * CPU) begin
            echo[c] = 1'b0;
            dropped = 1;
         end
         if (g_got && dropped && i > g_vi) break;
      end
   endtask

   int                     dist_m [N_CH];
   logic [N_CH-1:0]        to_m;
   logic [N_CH*DIST_W-1:0] exp_bus;
   int                     prev_rise;
   int                     n;

   initial begin
      vt[0]  = '{0, 200,  600, 10, 1'b0};
      vt[1]  = '{1,  50,  320,  5, 1'b0};
      vt[2]  = '{2, 100,  150,  2, 1'b0};
      vt[3]  = '{3,  30, 1000, 15, 1'b0};   // 17 cm saturates at 15
      vt[4]  = '{0,  10,   30,  0, 1'b0};
      vt[5]  = '{1,  10, 1400,  5, 1'b1};   // echo stuck high, keeps 5
      vt[6]  = '{2,   0,   -1,  2, 1'b1};   // no echo, keeps 2
      vt[7]  = '{3,  20,  490,  8, 1'b0};
      vt[8]  = '{0,  10, 1199, 15, 1'b0};   // just under timeout
      vt[9]  = '{1,  50,  600, 10, 1'b0};   // clears timeout[1]
      vt[10] = '{2,  40,  600, 10, 1'b0};
      vt[11] = '{3,   0,   -1,  8, 1'b1};
      vt[12] = '{0,  10,  150,  2, 1'b0};
      for (int k = 0; k < N_CH; k++) dist_m[k] = 0;
      to_m = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_trig", trig, 0);
      chk("rst_distance", distance, 0);
      chk("rst_valid", valid, 0);
      chk("rst_valid_ch", valid_ch, 0);
      chk("rst_timeout", timeout, 0);
      reset_p = 1'b0;

      prev_rise = -1;
      for (int i = 0; i < NV; i++) begin
         run_slot(vt[i].ch, vt[i].dly, vt[i].wid);
         dist_m[vt[i].ch] = vt[i].exp_dist;
         to_m[vt[i].ch]   = vt[i].exp_to;
         for (int k = 0; k < N_CH; k++) exp_bus[k*DIST_W +: DIST_W] = DIST_W'(dist_m[k]);
         chk($sformatf("v%0d_trig_onehot", i), g_trig, 1 << vt[i].ch);
         chk_rng($sformatf("v%0d_trig_width", i), g_tw, TRIG_US*CPU - 1, TRIG_US*CPU + 1);
         chk($sformatf("v%0d_valid", i), g_got, 1);
         chk($sformatf("v%0d_valid_ch", i), g_vch, vt[i].ch);
         chk($sformatf("v%0d_valid_pulse", i), g_vnext, 0);
         chk($sformatf("v%0d_distance", i), g_dist, exp_bus);
         chk($sformatf("v%0d_timeout", i), g_to, to_m);
         if (prev_rise >= 0)
            chk($sformatf("v%0d_slot_period", i), g_rcyc - prev_rise, SLOT_US*CPU);
         if (vt[i].wid >= 0 && vt[i].wid < TIMEOUT_US)
            chk($sformatf("v%0d_latency", i), g_lat, 4);
         if (vt[i].wid >= TIMEOUT_US)
            chk_rng($sformatf("v%0d_fail_time", i), g_vi, 2*TIMEOUT_US + 3, 2*TIMEOUT_US + 6);
         prev_rise = g_rcyc;
      end

      // reset in the middle of a channel 1 measurement
      n = 0;
      while (!trig[1] && n < 4000) begin @(posedge clk); #1; n++; end
      chk("rst_mid_trig1_seen", trig[1], 1);
      n = 0;
      while (trig[1] && n < 100) begin @(posedge clk); #1; n++; end
      repeat (40) begin @(posedge clk); #1; end
      echo[1] = 1'b1;
      repeat (200) begin @(posedge clk); #1; end
      reset_p = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_trig", trig, 0);
      chk("rst_mid_distance", distance, 0);
      chk("rst_mid_valid", valid, 0);
      chk("rst_mid_valid_ch", valid_ch, 0);
      chk("rst_mid_timeout", timeout, 0);
      @(posedge clk); #1;
      reset_p = 1'b0;
      echo[1] = 1'b0;
      n = 0;
      while (!trig[0] && n < 10) begin @(posedge clk); #1; n++; end
      chk_rng("rst_first_trig_delay", n, 1, 2);
      chk("rst_first_trig_bus", trig, 1);

      chk("distance_only_on_valid", glitch_cnt, 0);
      chk("trig_at_most_one", multi_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
